reset_sequencer: RTL

Staged reset controller for the RTC clock display design. It takes the board-level asynchronous reset, synchronises its release internally, and releases a set of downstream reset domains one at a time: RTC core first, then the time/BCD logic, then the display driver. It also services soft-reset and watchdog requests by re-asserting every domain and replaying the release sequence. A sticky reset-cause code is kept for the UI to read.

---
 rtl/reset_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Staged reset controller: synchronises board reset release and then
// releases downstream reset domains one at a time, with soft/watchdog restart.
//
// Ports:
//   clk             system clock
//   ext_reset       asynchronous active-high board reset (release synchronised)
//   soft_reset_req  single-cycle soft restart request
//   wdt_expire      single-cycle watchdog restart request
//   cause_clr       clears the sticky reset-cause code
//   stage_resetn    active-low reset per domain, bit 0 released first
//   ready           all domains released
//   busy            sequencer not in RUN
//   reset_cause     00 none, 01 external, 10 soft, 11 watchdog
module reset_sequencer #(
    parameter int N_STAGES   = 3,
    parameter int POR_CYCLES = 16,
    parameter int STAGE_GAP  = 4,
    parameter int SOFT_HOLD  = 8
) (
    input  logic                clk,
    input  logic                ext_reset,
    input  logic                soft_reset_req,
    input  logic                wdt_expire,
    input  logic                cause_clr,
    output logic [N_STAGES-1:0] stage_resetn,
    output logic                ready,
    output logic                busy,
    output logic [1:0]          reset_cause
);

    localparam int MAX_A = (POR_CYCLES > STAGE_GAP) ? POR_CYCLES : STAGE_GAP;
    localparam int MAX_C = (MAX_A > SOFT_HOLD) ? MAX_A : SOFT_HOLD;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int IW    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_REL,
        S_RUN,
        S_SOFT
    } state_e;

    // Both flops set asynchronously, so assertion of ext_reset reaches the
    // FSM immediately; release takes two edges.
    logic sync1_q;
    logic sync2_q;
    logic rst_int;

    always_ff @(posedge clk or posedge ext_reset) begin
        if (ext_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= 1'b0;
            sync2_q <= sync1_q;
        end
    end

    assign rst_int = sync2_q;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [N_STAGES-1:0]   stage_q, stage_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [1:0]            cause_q, cause_d;
    logic                  req;
    logic                  accept;

    assign req = soft_reset_req | wdt_expire;

    // State register (outputs are registered alongside the state)
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= 2'b01;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        accept  = 1'b0;
        unique case (state_q)
            S_HOLD: begin
                if (cnt_q == POR_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (N_STAGES == 1) ? S_RUN : S_REL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REL: begin
                if (req) begin
                    accept = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + IW'(1);
                    if (idx_d == IDX_LAST) begin
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (req) begin
                    accept = 1'b1;
                end
            end
            S_SOFT: begin
                if (cnt_q == SOFT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (N_STAGES == 1) ? S_RUN : S_REL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        if (accept) begin
            state_d = S_SOFT;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    // Output logic, evaluated on the next state so outputs change on the
    // same edge as the transition.
    always_comb begin
        stage_d = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            stage_d[i] = (state_d == S_RUN) ||
                         ((state_d == S_REL) && (i <= int'(idx_d)));
        end
        ready_d = (state_d == S_RUN);
        busy_d  = (state_d != S_RUN);
        cause_d = cause_q;
        if (accept) begin
            cause_d = wdt_expire ? 2'b11 : 2'b10;
        end else if (cause_clr) begin
            cause_d = 2'b00;
        end
    end

    assign stage_resetn = stage_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign reset_cause  = cause_q;

endmodule
